// File: rtl/id_operand_bypass_tracker_pkg.sv
// Shared pipeline definitions for the ID-stage operand bypass tracker:
// tracker entry layout, stage indices and forward-select encoding.
package id_operand_bypass_tracker_pkg;

    // Destination field is sized for the widest register address in use;
    // narrower register addresses are zero-extended into it.
    localparam int ENTRY_DST_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [ENTRY_DST_W-1:0] dst;
        logic                   reg_write;
        logic                   mem_read;
    } track_entry_t;

    localparam int ENTRY_W = $bits(track_entry_t);

    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    localparam int FWD_REGFILE = 0;

endpackage

// File: rtl/id_operand_bypass_tracker_match.sv
// Per-operand youngest-producer search over the tracker; purely combinational.
module id_bypass_match
    import id_operand_bypass_tracker_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 2,
    parameter int LOAD_READY = 3,
    parameter int SEL_W      = 2
) (
    input  logic [REG_ADDR_W-1:0]    src_addr_i,
    input  logic                     src_used_i,
    input  logic [DEPTH*ENTRY_W-1:0] tracker_i,
    output logic [SEL_W-1:0]         sel_o,
    output logic                     not_ready_o
);

    logic found;
    logic ready;
    logic mr_young;
    int   k_young;

    always_comb begin
        track_entry_t e;
        found    = 1'b0;
        k_young  = 0;
        mr_young = 1'b0;
        e        = '0;
        // Scan oldest to youngest so the lowest matching stage wins.
        for (int k = DEPTH; k >= STG_ID_EX; k--) begin
            e = track_entry_t'(tracker_i[(k-1)*ENTRY_W +: ENTRY_W]);
            if (src_used_i && e.valid && e.reg_write && (e.dst != '0) &&
                (e.dst == ENTRY_DST_W'(src_addr_i))) begin
                found    = 1'b1;
                k_young  = k;
                mr_young = e.mem_read;
            end
        end
        ready       = found && (k_young >= (mr_young ? LOAD_READY : ALU_READY));
        sel_o       = ready ? SEL_W'(k_young) : SEL_W'(FWD_REGFILE);
        not_ready_o = found && !ready;
    end

endmodule

// File: rtl/id_operand_bypass_tracker.sv
// ID-stage bypass tracker: shadows in-flight destinations behind ID, picks
// forward sources, raises load-use / ALU-to-branch stalls, counts stall cycles.
module id_operand_bypass_tracker
    import id_operand_bypass_tracker_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 2,
    parameter int LOAD_READY = 3,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dst_addr,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          hold,
    input  logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic                          stall,
    output logic [CNT_W-1:0]              stall_cycles
);

    track_entry_t [DEPTH-1:0] tracker_q, tracker_d;
    track_entry_t             id_entry;
    logic [NUM_SRC-1:0]       not_ready;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        id_bypass_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .ALU_READY  (ALU_READY),
            .LOAD_READY (LOAD_READY),
            .SEL_W      (SEL_W)
        ) u_match (
            .src_addr_i  (id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .src_used_i  (id_valid && id_src_used[i]),
            .tracker_i   (tracker_q),
            .sel_o       (fwd_sel[i*SEL_W +: SEL_W]),
            .not_ready_o (not_ready[i])
        );
    end

    assign stall        = |not_ready;
    assign stall_cycles = cnt_q;

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = 1'b1;
        id_entry.dst       = ENTRY_DST_W'(id_dst_addr);
        id_entry.reg_write = id_reg_write;
        id_entry.mem_read  = id_mem_read;
    end

    always_comb begin
        tracker_d = tracker_q;
        if (flush) begin
            tracker_d = '0;
        end else if (!hold) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                tracker_d[k] = tracker_q[k-1];
            end
            // A stalled ID instruction is replaced by a bubble entering EX.
            tracker_d[0] = (id_valid && !stall) ? id_entry : '0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !hold && !flush && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tracker_q <= '0;
            cnt_q     <= '0;
        end else begin
            tracker_q <= tracker_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_id_operand_bypass_tracker.sv
// Directed bench for id_operand_bypass_tracker with hand-computed expectations.
module tb_id_operand_bypass_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst_addr;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        hold;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    id_operand_bypass_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_src_addr  (id_src_addr),
        .id_src_used  (id_src_used),
        .id_dst_addr  (id_dst_addr),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .hold         (hold),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst,
                         input logic rw, input logic mr);
        id_valid     = v;
        id_src_addr  = {s1, s0};
        id_src_used  = used;
        id_dst_addr  = dst;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall); end
        tests++; if (fwd_sel !== 4'h0) begin fails++; $display("FAIL reset_fwd: got %h want 0", fwd_sel); end
        tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
        drive(1'b1, 5'd3, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0);
        tests++; if ({stall, fwd_sel} !== 5'h0) begin fails++; $display("FAIL reset_empty_tracker: got %h want 0", {stall, fwd_sel}); end
    endtask

    task automatic test_alu_branch();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);   // add r3,r1,r2
        tick();
        drive(1'b1, 5'd3, 5'd1, 2'b11, 5'd0, 1'b0, 1'b0);   // beq r3,r1
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL alu_br_stall: got %0b want 1", stall); end
        tests++; if (fwd_sel !== 4'h0) begin fails++; $display("FAIL alu_br_fwd_stalled: got %h want 0", fwd_sel); end
        tick();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL alu_br_release: got %0b want 0", stall); end
        tests++; if (fwd_sel !== 4'b0010) begin fails++; $display("FAIL alu_br_fwd: got %h want 2", fwd_sel); end
        tests++; if (stall_cycles !== 16'd1) begin fails++; $display("FAIL alu_br_cnt: got %0d want 1", stall_cycles); end
        tick();
        tests++; if (stall_cycles !== 16'd1) begin fails++; $display("FAIL alu_br_cnt_hold: got %0d want 1", stall_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);   // lw r4
        tick();
        drive(1'b1, 5'd4, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0);   // add r5,r4,r4
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall1: got %0b want 1", stall); end
        tick();
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL lu_stall2: got %0b want 1", stall); end
        tests++; if (fwd_sel !== 4'h0) begin fails++; $display("FAIL lu_no_early_fwd: got %h want 0", fwd_sel); end
        tick();
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL lu_release: got %0b want 0", stall); end
        tests++; if (fwd_sel !== 4'b1111) begin fails++; $display("FAIL lu_fwd: got %h want f", fwd_sel); end
        tests++; if (stall_cycles !== 16'd2) begin fails++; $display("FAIL lu_cnt: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd1, 2'b11, 5'd0, 1'b0, 1'b0);
        tests++; if ({stall, fwd_sel} !== 5'b0_0010) begin fails++; $display("FAIL young_alu: got %h want 02", {stall, fwd_sel}); end

        do_reset();
        drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0);   // ALU r6
        tick();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd0, 2'b01, 5'd6, 1'b1, 1'b1);   // lw r6
        tick();
        drive(1'b1, 5'd6, 5'd1, 2'b11, 5'd0, 1'b0, 1'b0);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL young_load_stall: got %0b want 1", stall); end
        tests++; if (fwd_sel !== 4'h0) begin fails++; $display("FAIL young_no_older: got %h want 0", fwd_sel); end
    endtask

    task automatic test_r0_unused();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0);   // writes r0
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0);
        tests++; if ({stall, fwd_sel} !== 5'h0) begin fails++; $display("FAIL r0_nomatch: got %h want 0", {stall, fwd_sel}); end

        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd9, 1'b1, 1'b1);   // lw r9
        tick();
        drive(1'b1, 5'd1, 5'd9, 2'b01, 5'd0, 1'b0, 1'b0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL unused_rt: got %0b want 0", stall); end
        drive(1'b1, 5'd1, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0);
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL used_rt: got %0b want 1", stall); end
        drive(1'b0, 5'd1, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL invalid_id: got %0b want 0", stall); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);   // lw r7
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);   // consumer writes r8
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL flush_pre_stall: got %0b want 1", stall); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        tests++; if ({stall, fwd_sel} !== 5'h0) begin fails++; $display("FAIL flush_clear: got %h want 0", {stall, fwd_sel}); end
        tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL flush_cnt: got %0d want 0", stall_cycles); end
        drive(1'b1, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_no_insert: got %0b want 0", stall); end

        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
        flush = 1'b1;
        hold  = 1'b1;
        tick();
        flush = 1'b0;
        hold  = 1'b0;
        #1;
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_over_hold: got %0b want 0", stall); end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd4, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0);
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hold_stall c%0d: got %0b want 1", c, stall); end
            tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL hold_cnt c%0d: got %0d want 0", c, stall_cycles); end
        end
        drive(1'b0, 5'd4, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL hold_tracks_id: got %0b want 0", stall); end
        drive(1'b1, 5'd4, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0);
        hold = 1'b0;
        tick();
        tests++; if (stall !== 1'b1) begin fails++; $display("FAIL hold_frozen_stage: got %0b want 1", stall); end
        tests++; if (stall_cycles !== 16'd1) begin fails++; $display("FAIL hold_cnt_resume: got %0d want 1", stall_cycles); end
        tick();
        tests++; if (fwd_sel !== 4'b1111 || stall !== 1'b0) begin fails++; $display("FAIL hold_fwd: got %h/%0b want f/0", fwd_sel, stall); end
        tests++; if (stall_cycles !== 16'd2) begin fails++; $display("FAIL hold_cnt_end: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd4, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd4, 5'd4, 2'b11, 5'd5, 1'b1, 1'b0);
        tick();
        tests++; if (stall_cycles !== 16'd1) begin fails++; $display("FAIL rms_pre_cnt: got %0d want 1", stall_cycles); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        tests++; if ({stall, fwd_sel} !== 5'h0) begin fails++; $display("FAIL rms_outputs: got %h want 0", {stall, fwd_sel}); end
        tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL rms_cnt: got %0d want 0", stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_alu_branch();
        test_load_use();
        test_youngest();
        test_r0_unused();
        test_flush();
        test_hold();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
